// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: read-side consumer of a 16x8 synchronous FIFO that serialises
// each popped byte onto tx as an LSB-first asynchronous frame (start, 8 data,
// stop). Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between
// data bit 7 and the stop bit (11-bit frames instead of 10).
// A producer write in the same cycle as our read wins, so the read is only
// counted as accepted when no write is landing; a rejected read just retries.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_en,
  input  logic        fifo_empty,
  input  logic        fifo_full,
  input  logic        fifo_wr,
  input  logic [7:0]  fifo_dout,
  output logic        fifo_rd,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_MAX = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          rd_q, rd_d;
  logic [15:0]   frames_q;
  logic          frame_done;
`ifdef FIFO_UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  // State and datapath registers; reset parks the line idle-high and drops
  // any byte already captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Completed-frame counter; only written when a stop bit finishes, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_q <= '0;
    end else if (frame_done) begin
      frames_q <= frames_q + 16'd1;
    end
  end

  // Next-state logic: tx and fifo_rd are computed one cycle ahead so both leave registers.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    rd_d       = 1'b0;
    frame_done = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // tx_en is only looked at here, so dropping it mid-frame is harmless.
        if (tx_en && !fifo_empty) begin
          state_d = REQ;
          rd_d    = 1'b1;
        end
      end
      REQ: begin
        // A write landing this cycle blocks the read; go back and ask again.
        if (!fifo_empty && !(fifo_wr && !fifo_full)) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        shift_d = fifo_dout;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = ^fifo_dout;
`endif
        tx_d    = 1'b0;
        timer_d = T_MAX;
        state_d = START;
      end
      START: begin
        if (timer_q == '0) begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = 3'd0;
          timer_d = T_MAX;
          state_d = DATA;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          timer_d = T_MAX;
          if (idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            idx_d   = idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (timer_q == '0) begin
          tx_d    = 1'b1;
          timer_d = T_MAX;
          state_d = STOP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
`endif
      STOP: begin
        if (timer_q == '0) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx          = tx_q;
  assign fifo_rd     = rd_q;
  assign busy        = (state_q != IDLE);
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: a queue-based FIFO model feeds the DUT, and the
// tx line is compared cycle by cycle against frames built from the byte values.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en = 1'b0;
  logic        fifo_wr = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_empty, fifo_full;
  logic        fifo_rd, tx, busy;
  logic [15:0] frames_sent;

  int          checks = 0;
  int          errors = 0;
  int          rd_count = 0;
  int          fcount = 0;
  logic [15:0] exp_frames = 16'h0000;
  logic [7:0]  q[$];

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .tx_en(tx_en),
    .fifo_empty(fifo_empty),
    .fifo_full(fifo_full),
    .fifo_wr(fifo_wr),
    .fifo_dout(fifo_dout),
    .fifo_rd(fifo_rd),
    .tx(tx),
    .busy(busy),
    .frames_sent(frames_sent)
  );

  // Behavioural 16-deep FIFO: write has priority over a read in the same cycle.
  assign fifo_empty = (fcount == 0);
  assign fifo_full  = (fcount >= 16);

  always @(posedge clk) begin
    logic wr_ok, rd_ok;
    wr_ok = fifo_wr && (q.size() < 16);
    rd_ok = fifo_rd && (q.size() > 0) && !wr_ok;
    if (rd_ok) begin
      fifo_dout <= q[0];
      void'(q.pop_front());
    end
    if (wr_ok) q.push_back(wdata);
    if (fifo_rd) rd_count <= rd_count + 1;
    fcount <= q.size();
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_wr = 1'b1;
    wdata   = b;
    @(negedge clk);
    fifo_wr = 1'b0;
  endtask

  // Expected line level of serial bit k of a frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NBITS == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Wait for a start bit, then check every bit cell is held for CPB cycles.
  task automatic check_frame(input logic [7:0] b, input int drop_at);
    int w = 0;
    int cyc = 0;
    logic [CPB-1:0] obs;
    while (tx !== 1'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("start_%02h_seen", b), 32'(w < 200), 1);
    if (w < 200) begin
      for (int k = 0; k < NBITS; k++) begin
        for (int c = 0; c < CPB; c++) begin
          obs[c] = tx;
          if (cyc == drop_at) tx_en = 1'b0;
          cyc++;
          @(negedge clk);
        end
        check($sformatf("frame_%02h_bit%0d", b, k), 32'(obs), 32'({CPB{frame_bit(b, k)}}));
      end
      exp_frames = exp_frames + 16'd1;
    end
  endtask

  task automatic check_gap(input string tag);
    int g = 0;
    while (tx === 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check(tag, g, 3);
  endtask

  task automatic count_lows(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      if (tx !== 1'b1) lows++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] rb[6];
    int rd0, lows, w;

    // Reset state
    rst = 1'b1;
    cycles(3);
    check("rst_tx", 32'(tx), 1);
    check("rst_rd", 32'(fifo_rd), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frames", 32'(frames_sent), 0);
    rst = 1'b0;
    cycles(1);

    // Single byte 0xA5 with start-latency checks
    push(8'hA5);
    cycles(2);
    check("gated_busy", 32'(busy), 0);
    check("gated_rd", 32'(fifo_rd), 0);
    rd0 = rd_count;
    tx_en = 1'b1;
    cycles(1);
    check("lat_rd_high", 32'(fifo_rd), 1);
    check("lat_busy", 32'(busy), 1);
    cycles(1);
    check("lat_rd_low", 32'(fifo_rd), 0);
    check("lat_tx_high", 32'(tx), 1);
    cycles(1);
    check("lat_tx_low", 32'(tx), 0);
    check_frame(8'hA5, -1);
    check("single_frames", 32'(frames_sent), 32'(exp_frames));
    check("single_busy", 32'(busy), 0);
    check("single_rd_pulses", rd_count - rd0, 1);

    // Back-to-back 0x00 then 0xFF
    tx_en = 1'b0;
    push(8'h00);
    push(8'hFF);
    tx_en = 1'b1;
    check_frame(8'h00, -1);
    check_gap("b2b_gap");
    check_frame(8'hFF, -1);
    check("b2b_frames", 32'(frames_sent), 32'(exp_frames));
    count_lows(10, lows);
    check("b2b_idle_lows", lows, 0);
    check("b2b_idle_busy", 32'(busy), 0);

    // Write/read collision during REQ
    tx_en = 1'b0;
    push(8'h3C);
    rd0 = rd_count;
    tx_en = 1'b1;
    cycles(1);
    check("coll_req", 32'(fifo_rd), 1);
    fifo_wr = 1'b1;
    wdata   = 8'h99;
    cycles(1);
    fifo_wr = 1'b0;
    check("coll_idle_busy", 32'(busy), 0);
    check("coll_idle_rd", 32'(fifo_rd), 0);
    cycles(1);
    check("coll_retry_rd", 32'(fifo_rd), 1);
    check_frame(8'h3C, -1);
    check_gap("coll_gap");
    check_frame(8'h99, -1);
    check("coll_rd_pulses", rd_count - rd0, 3);
    check("coll_frames", 32'(frames_sent), 32'(exp_frames));

    // tx_en dropped during DATA: frame completes, nothing new starts
    tx_en = 1'b0;
    push(8'h11);
    push(8'h22);
    tx_en = 1'b1;
    check_frame(8'h11, CPB * 3);
    check("gate_frames", 32'(frames_sent), 32'(exp_frames));
    rd0 = rd_count;
    count_lows(30, lows);
    check("gate_lows", lows, 0);
    check("gate_rd", rd_count - rd0, 0);
    check("gate_busy", 32'(busy), 0);
    tx_en = 1'b1;
    check_frame(8'h22, -1);

    // Randomized stream (first byte 0x07 exercises odd parity)
    tx_en = 1'b0;
    rb[0] = 8'h07;
    for (int i = 1; i < 6; i++) rb[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) push(rb[i]);
    tx_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) check_gap($sformatf("rand_gap%0d", i));
      check_frame(rb[i], -1);
    end
    check("rand_frames", 32'(frames_sent), 32'(exp_frames));

    // Reset during DATA bit 3
    push(8'hC3);
    w = 0;
    while (tx !== 1'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("rstmid_start_seen", 32'(w < 200), 1);
    cycles(CPB * 4 + 1);
    rst = 1'b1;
    cycles(1);
    check("rstmid_tx", 32'(tx), 1);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_frames", 32'(frames_sent), 0);
    rst = 1'b0;
    exp_frames = 16'h0000;
    rd0 = rd_count;
    count_lows(20, lows);
    check("rstmid_lows", lows, 0);
    check("rstmid_rd", rd_count - rd0, 0);
    push(8'h5A);
    check_frame(8'h5A, -1);
    check("rstmid_after_frames", 32'(frames_sent), 32'(exp_frames));

    // Counter wrap 0xFFFF -> 0x0000
    force dut.frames_q = 16'hFFFF;
    cycles(1);
    release dut.frames_q;
    cycles(1);
    check("wrap_preload", 32'(frames_sent), 32'h0000FFFF);
    exp_frames = 16'hFFFF;
    push(8'h96);
    check_frame(8'h96, -1);
    check("wrap_frames", 32'(frames_sent), 32'(exp_frames));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
